dda_traversal: RTL

DDA_TRAVERSAL -- requirements
Module: dda_traversal

---
 rtl/raycast_pkg.sv | 28 ++
 rtl/dda_traversal.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/raycast_pkg.sv
// Shared raycaster definitions: DDA state encoding, map geometry defaults and
// the wall code reported when a ray leaves the map or runs out of steps.
package raycast_pkg;

  localparam int         MAP_SIZE      = 24;
  localparam logic [3:0] WALL_BOUNDARY = 4'hF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP  = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DIST  = 3'd4,
    OUT   = 3'd5
  } dda_state_e;

  // Q8.8 accumulate that pins at full scale instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  function automatic logic [15:0] sub_clamp16(input logic [15:0] a, input logic [15:0] b);
    return (a >= b) ? (a - b) : 16'h0000;
  endfunction

endpackage

// File: rtl/dda_traversal.sv
// Grid DDA walker: steps a ray cell by cell through an external map BRAM and
// reports the perpendicular wall distance, hit face and cell type per column.
module dda_traversal #(
  parameter int MAP_SIZE     = raycast_pkg::MAP_SIZE,
  parameter int BRAM_LATENCY = 2,
  parameter int MAX_STEPS    = 64
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        valid_ray_in,
  output logic        dda_data_ready_out,
  input  logic [8:0]  hcount_in,
  input  logic [15:0] posX,
  input  logic [15:0] posY,
  input  logic        stepX,
  input  logic        stepY,
  input  logic [15:0] sideDistX,
  input  logic [15:0] sideDistY,
  input  logic [15:0] deltaDistX,
  input  logic [15:0] deltaDistY,
  output logic [9:0]  map_addr_out,
  input  logic [3:0]  map_data_in,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [8:0]  hcount_out,
  output logic [15:0] perpWallDist,
  output logic        wall_side,
  output logic [3:0]  wall_type
);
  import raycast_pkg::*;

  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam int WW = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;
  localparam logic [SW-1:0]     STEP_LIMIT = SW'(MAX_STEPS);
  localparam logic [WW-1:0]     WAIT_LAST  = WW'(BRAM_LATENCY - 1);
  localparam logic signed [9:0] MAP_LIM    = 10'(MAP_SIZE);

  dda_state_e state_r, state_next_s;

  logic               ready_r, valid_r;
  logic [8:0]         hcount_r, hcount_out_r;
  logic               step_x_r, step_y_r, side_r, side_out_r, timeout_r;
  logic [15:0]        side_x_r, side_y_r, delta_x_r, delta_y_r, perp_r;
  logic signed [9:0]  map_x_r, map_y_r;
  logic [SW-1:0]      step_cnt_r;
  logic [WW-1:0]      wait_cnt_r;
  logic [3:0]         type_r, type_out_r;
  logic [9:0]         map_addr_r;

  logic               accept_s, take_x_s, oob_s, hit_s;
  logic signed [9:0]  next_x_s, next_y_s;
  logic [9:0]         next_addr_s;
  logic [15:0]        pos_frac_unused_s;

  assign pos_frac_unused_s = {posX[7:0], posY[7:0]};

  assign accept_s = valid_ray_in && ready_r && (state_r == IDLE);
  assign take_x_s = side_x_r < side_y_r;
  assign hit_s    = map_data_in != 4'h0;
  assign next_x_s = take_x_s ? (step_x_r ? map_x_r + 10'sd1 : map_x_r - 10'sd1) : map_x_r;
  assign next_y_s = take_x_s ? map_y_r : (step_y_r ? map_y_r + 10'sd1 : map_y_r - 10'sd1);
  assign oob_s    = (next_x_s < 10'sd0) || (next_y_s < 10'sd0) ||
                    (next_x_s >= MAP_LIM) || (next_y_s >= MAP_LIM);
  // Only meaningful when in bounds; out-of-range cells never reach the address port.
  assign next_addr_s = 10'({10'd0, next_y_s} * 20'(MAP_SIZE) + {10'd0, next_x_s});

  // State register.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_next_s = STEP; else state_next_s = IDLE;
      STEP:    if (oob_s) state_next_s = DIST; else state_next_s = WAIT;
      WAIT:    if (wait_cnt_r == WAIT_LAST) state_next_s = CHECK; else state_next_s = WAIT;
      CHECK:   if (hit_s || (step_cnt_r == STEP_LIMIT)) state_next_s = DIST;
               else state_next_s = STEP;
      DIST:    state_next_s = OUT;
      OUT:     if (ready_in) state_next_s = IDLE; else state_next_s = OUT;
      default: state_next_s = IDLE;
    endcase
  end

  // Ray datapath and registered result outputs.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ready_r      <= 1'b0;
      valid_r      <= 1'b0;
      hcount_r     <= 9'd0;
      hcount_out_r <= 9'd0;
      step_x_r     <= 1'b0;
      step_y_r     <= 1'b0;
      side_r       <= 1'b0;
      side_out_r   <= 1'b0;
      timeout_r    <= 1'b0;
      side_x_r     <= 16'h0000;
      side_y_r     <= 16'h0000;
      delta_x_r    <= 16'h0000;
      delta_y_r    <= 16'h0000;
      perp_r       <= 16'h0000;
      map_x_r      <= 10'sd0;
      map_y_r      <= 10'sd0;
      step_cnt_r   <= '0;
      wait_cnt_r   <= '0;
      type_r       <= 4'h0;
      type_out_r   <= 4'h0;
      map_addr_r   <= 10'd0;
    end else begin
      // Ready rises the cycle after reset release, then tracks IDLE exactly.
      ready_r <= (state_next_s == IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            hcount_r   <= hcount_in;
            step_x_r   <= stepX;
            step_y_r   <= stepY;
            side_x_r   <= sideDistX;
            side_y_r   <= sideDistY;
            delta_x_r  <= deltaDistX;
            delta_y_r  <= deltaDistY;
            map_x_r    <= {2'b00, posX[15:8]};
            map_y_r    <= {2'b00, posY[15:8]};
            step_cnt_r <= '0;
            timeout_r  <= 1'b0;
            type_r     <= 4'h0;
          end
        end
        STEP: begin
          if (take_x_s) begin
            side_x_r <= sat_add16(side_x_r, delta_x_r);
            side_r   <= 1'b0;
          end else begin
            side_y_r <= sat_add16(side_y_r, delta_y_r);
            side_r   <= 1'b1;
          end
          map_x_r    <= next_x_s;
          map_y_r    <= next_y_s;
          step_cnt_r <= step_cnt_r + SW'(1);
          wait_cnt_r <= '0;
          if (oob_s) begin
            type_r <= WALL_BOUNDARY;
          end else begin
            map_addr_r <= next_addr_s;
          end
        end
        WAIT: wait_cnt_r <= wait_cnt_r + WW'(1);
        CHECK: begin
          if (hit_s) begin
            type_r <= map_data_in;
          end else if (step_cnt_r == STEP_LIMIT) begin
            type_r    <= WALL_BOUNDARY;
            timeout_r <= 1'b1;
          end
        end
        DIST: begin
          perp_r       <= timeout_r ? 16'hFFFF :
                          (side_r ? sub_clamp16(side_y_r, delta_y_r)
                                  : sub_clamp16(side_x_r, delta_x_r));
          side_out_r   <= side_r;
          type_out_r   <= type_r;
          hcount_out_r <= hcount_r;
          valid_r      <= 1'b1;
        end
        OUT: if (ready_in) valid_r <= 1'b0;
        default: valid_r <= 1'b0;
      endcase
    end
  end

  assign dda_data_ready_out = ready_r;
  assign valid_out          = valid_r;
  assign map_addr_out       = map_addr_r;
  assign hcount_out         = hcount_out_r;
  assign perpWallDist       = perp_r;
  assign wall_side          = side_out_r;
  assign wall_type          = type_out_r;

endmodule
